uart_result_formatter: RTL

- Downstream consumer of the 8-bit sum result (the adder output that also drives the LEDs and the 7-segment display).
- Converts the sum to unsigned decimal ASCII using a sequential double-dabble and pushes the characters into the UART TX FIFO through the write_uart/write_data interface.
- An optional CR LF terminator follows the digits.
- Replaces the fixed "received byte + 1" echo path with a human-readable result on the serial link.

---
 rtl/uart_result_formatter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/uart_result_formatter.sv
// Converts a binary result to unsigned decimal ASCII (sequential double-dabble) and
// streams the characters into a UART TX FIFO. Define UART_FMT_CRLF_EN to append CR LF.
module uart_result_formatter #(
  parameter int DATA_WIDTH = 8,
  parameter int DIGITS     = 3
) (
  input  logic                  clk_100MHz,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  tx_full,
  output logic                  write_uart,
  output logic [7:0]            write_data,
  output logic                  busy,
  output logic                  done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONVERT,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  state_t                r_state, w_state_n;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_n;
  logic [BCD_W-1:0]      r_bcd, w_bcd_n, w_bcd_adj;
  logic [CNT_W-1:0]      r_cnt, w_cnt_n;
  logic [DIG_W-1:0]      r_dig, w_dig_n, w_first;
  logic [3:0]            w_nib;
  logic [7:0]            w_char;
  logic                  r_write, w_write_n;
  logic [7:0]            r_data, w_data_n;
  logic                  r_busy, w_busy_n;
  logic                  r_done, w_done_n;
`ifdef UART_FMT_CRLF_EN
  // 0: digits, 1: CR, 2: LF
  logic [1:0]            r_tail, w_tail_n;
`endif

  // Per-digit +3 adjust, most significant non-zero digit, and the digit at r_dig.
  always_comb begin
    w_bcd_adj = '0;
    w_first   = '0;
    w_nib     = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3
                                                      : r_bcd[4*i +: 4];
      if (r_bcd[4*i +: 4] != 4'd0) w_first = DIG_W'(i);
      if (DIG_W'(i) == r_dig)      w_nib   = r_bcd[4*i +: 4];
    end
  end

  always_comb begin
    w_char = 8'h30 + {4'h0, w_nib};
`ifdef UART_FMT_CRLF_EN
    if (r_tail == 2'd1) w_char = 8'h0D;
    if (r_tail == 2'd2) w_char = 8'h0A;
`endif
  end

  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_bcd_n   = r_bcd;
    w_cnt_n   = r_cnt;
    w_dig_n   = r_dig;
    w_write_n = 1'b0;
    w_data_n  = r_data;
    w_done_n  = 1'b0;
`ifdef UART_FMT_CRLF_EN
    w_tail_n  = r_tail;
`endif
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_shift_n = value;
          w_bcd_n   = '0;
          w_cnt_n   = '0;
          w_dig_n   = '0;
`ifdef UART_FMT_CRLF_EN
          w_tail_n  = 2'd0;
`endif
          w_state_n = S_CONVERT;
        end
      end
      S_CONVERT: begin
        // DATA_WIDTH shift cycles, then one cycle to pick the first digit from settled BCD.
        if (r_cnt == CNT_W'(DATA_WIDTH)) begin
          w_dig_n   = w_first;
          w_state_n = S_SEND;
        end else begin
          {w_bcd_n, w_shift_n} = {w_bcd_adj, r_shift} << 1;
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_SEND: begin
        if (!tx_full) begin
          w_write_n = 1'b1;
          w_data_n  = w_char;
          w_state_n = S_GAP;
        end
      end
      S_GAP: begin
        w_state_n = S_DONE;
        if (r_dig != '0) begin
          w_dig_n   = r_dig - 1'b1;
          w_state_n = S_SEND;
        end
`ifdef UART_FMT_CRLF_EN
        else if (r_tail != 2'd2) begin
          w_tail_n  = r_tail + 2'd1;
          w_state_n = S_SEND;
        end
`endif
      end
      S_DONE: begin
        w_done_n  = 1'b1;
        w_state_n = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
    w_busy_n = (w_state_n != S_IDLE);
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
      r_dig   <= '0;
      r_write <= 1'b0;
      r_data  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef UART_FMT_CRLF_EN
      r_tail  <= '0;
`endif
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_bcd   <= w_bcd_n;
      r_cnt   <= w_cnt_n;
      r_dig   <= w_dig_n;
      r_write <= w_write_n;
      r_data  <= w_data_n;
      r_busy  <= w_busy_n;
      r_done  <= w_done_n;
`ifdef UART_FMT_CRLF_EN
      r_tail  <= w_tail_n;
`endif
    end
  end

  assign write_uart = r_write;
  assign write_data = r_data;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
